hit_event_manager: RTL
======================

// Module: hit_event_manager
// PURPOSE
//  Parametrised collision manager for NUM_MONSTERS monsters. Sits between the object drawers and the game
//  controller. Drives combinational pixel-level collision flags and once-per-frame registered hit pulses.
//  Queues typed, monster-tagged hit events into a FIFO with a valid/ready handshake, and applies a
//  post-hit holdoff window to pacman-monster hits.
// PARAMETERS
//  NUM_MONSTERS    4  number of monster drawing-request inputs (1..8)
//  ID_W            3  width of monster id field; must satisfy 2**ID_W >= NUM_MONSTERS
//  FIFO_DEPTH      4  event FIFO entries; power of 2, >= 2
//  HOLDOFF_FRAMES  2  frames during which pacman-monster hits are ignored after one is accepted (0 = none)
// PORTS
//  clk                     in   1        system clock
//  resetN                  in   1        asynchronous, active-low reset
//  startOfFrame            in   1        one-cycle pulse at the start of each frame
//  dr_pacman               in   1        pacman drawing request
//  dr_tiles                in   1        tile drawing request
//  dr_bracket              in   1        bracket drawing request
//  dr_coins                in   1        coin drawing request
//  dr_monster              in   NUM_MONSTERS  monster drawing requests; bit i = monster i
//  collision_pacman        out  1        comb: dr_pacman & (dr_tiles | dr_bracket)
//  collision_monster_tile  out  NUM_MONSTERS  comb: bit i = dr_monster[i] & (dr_tiles | dr_bracket)
//  collision_monster_pacman out NUM_MONSTERS  comb: bit i = dr_monster[i] & dr_pacman
//  wallHit                 out  1        registered 1-cycle pulse; first pacman-tile hit in the frame
//  coinTaken               out  1        registered 1-cycle pulse; first pacman-coin hit in the frame
//  monsterHit              out  1        registered 1-cycle pulse; first accepted pacman-monster hit in the frame
//  evt_valid               out  1        FIFO not empty
//  evt_code                out  2+ID_W   {type[1:0], id}; type 00 = wall, 01 = coin, 10 = monster; id = 0 unless monster
//  evt_ready               in   1        consumer pops the head when evt_valid & evt_ready
//  evt_overflow            out  1        1-cycle pulse when an event is dropped
//  holdoff_active          out  1        high while the holdoff counter is nonzero
// BEHAVIOUR
//  Reset: all flags, pending bits, FIFO pointers/count, holdoff counter and registered outputs = 0.
//  Per-frame flags: flag_wall, flag_coin, flag_mon[i]. All cleared on startOfFrame.
//  - If startOfFrame and a collision occur in the same cycle, the collision is checked against the cleared
//    flag, so it is accepted and the flag ends at 1.
//  Acceptance (cycle T):
//  - pacman-tile uses dr_tiles only; bracket does not count.
//  - A collision whose flag is clear sets the flag and its pending bit at T+1.
//  - wallHit / coinTaken pulse at T+1.
//  - monsterHit pulses at T+1 once per frame, even if several monsters are accepted.
//  - Pacman-monster collisions are ignored entirely while holdoff_active = 1; no flag or pending bit is set.
//  Holdoff:
//  - Loaded with HOLDOFF_FRAMES on the cycle after any monster acceptance.
//  - Decremented on each startOfFrame while nonzero.
//  - Reload wins over decrement when both occur in the same cycle.
//  Drain: at most one pending bit is pushed to the FIFO per cycle.
//  - Priority: lowest-index monster, then coin, then wall.
//  - The push clears that pending bit.
//  - No push while the FIFO is full; a pending bit then holds across frame boundaries.
//  - If an event is accepted while its pending bit is already set, the event is dropped and evt_overflow
//    pulses. This is the only loss path.
//  FIFO:
//  - Push and pop in the same cycle is allowed when full or empty-with-push-bypass is not used.
//  - Count stays unchanged.
//  - A pop with evt_valid = 0 is ignored.
//  - evt_code is driven from the head register; it is stable while evt_valid & !evt_ready.
//  - Pointers wrap modulo FIFO_DEPTH.
//  Latency: collision at T -> pending at T+1 -> earliest push at T+1 -> evt_valid at T+2.
//  Mid-operation reset: all state is cleared immediately; queued events are lost, with no overflow pulse.
// TESTING
//  1. Pacman on a tile for 10 cycles in one frame -> one wallHit pulse, one event 00_000. Next frame repeats.
//  2. dr_monster = 4'b0110 with pacman in the same cycle, HOLDOFF_FRAMES = 2:
//     -> monsterHit pulses once; events 10_001 then 10_010;
//     -> monster hits ignored for the next 2 startOfFrames.
//  3. evt_ready = 0, four distinct events (fills depth 4), then a coin hit:
//     -> coin stays pending, no overflow;
//     -> another coin hit the next frame -> evt_overflow pulses once.
//  4. startOfFrame coincident with a pacman-coin collision after an earlier coin hit in the frame
//     -> coinTaken pulses again.
//  5. Full FIFO, evt_ready = 1 with a pending wall -> pop and push in the same cycle; count stays 4.
//  6. Assert resetN low with 3 events queued -> evt_valid = 0 and all outputs 0 asynchronously.

Source files
------------

// File: rtl/hit_event_manager.sv
// hit_event_manager
//   Collision manager that sits between the object drawers and the game controller.
//   Pixel-level collision flags are combinational. Pacman hits are registered into
//   once-per-frame pulses. Each accepted hit also becomes a typed, monster-tagged
//   event in a small FIFO that the consumer reads with valid/ready. After a
//   pacman-monster hit is accepted, further monster hits are ignored for
//   HOLDOFF_FRAMES frames.
//
// Ports
//   clk, resetN                 clock, asynchronous active-low reset
//   startOfFrame                one-cycle pulse at each frame start
//   dr_pacman/tiles/bracket/coins, dr_monster[NUM_MONSTERS]   drawing requests
//   collision_pacman            comb, pacman over tile or bracket
//   collision_monster_tile      comb, per-monster over tile or bracket
//   collision_monster_pacman    comb, per-monster over pacman
//   wallHit/coinTaken/monsterHit  registered first-hit-of-frame pulses
//   evt_valid/evt_code/evt_ready  event FIFO head, code = {type[1:0], id}
//   evt_overflow                pulse when an event is dropped
//   holdoff_active              monster-hit holdoff counter is nonzero
module hit_event_manager #(
   parameter int NUM_MONSTERS   = 4,
   parameter int ID_W           = 3,
   parameter int FIFO_DEPTH     = 4,
   parameter int HOLDOFF_FRAMES = 2
) (
   input  logic                    clk,
   input  logic                    resetN,
   input  logic                    startOfFrame,
   input  logic                    dr_pacman,
   input  logic                    dr_tiles,
   input  logic                    dr_bracket,
   input  logic                    dr_coins,
   input  logic [NUM_MONSTERS-1:0] dr_monster,
   output logic                    collision_pacman,
   output logic [NUM_MONSTERS-1:0] collision_monster_tile,
   output logic [NUM_MONSTERS-1:0] collision_monster_pacman,
   output logic                    wallHit,
   output logic                    coinTaken,
   output logic                    monsterHit,
   output logic                    evt_valid,
   output logic [ID_W+1:0]         evt_code,
   input  logic                    evt_ready,
   output logic                    evt_overflow,
   output logic                    holdoff_active
);

   localparam int CODE_W = 2 + ID_W;
   localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int AW1    = AW + 1;
   localparam int HW     = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;

   localparam logic [AW:0]   DEPTH_C   = AW1'(FIFO_DEPTH);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_FRAMES);
   localparam logic [1:0]    TYPE_WALL = 2'b00;
   localparam logic [1:0]    TYPE_COIN = 2'b01;
   localparam logic [1:0]    TYPE_MON  = 2'b10;

   logic                    flag_wall_q, flag_wall_d;
   logic                    flag_coin_q, flag_coin_d;
   logic [NUM_MONSTERS-1:0] flag_mon_q,  flag_mon_d;
   logic                    flag_mhit_q, flag_mhit_d;

   logic                    pend_wall_q, pend_wall_d;
   logic                    pend_coin_q, pend_coin_d;
   logic [NUM_MONSTERS-1:0] pend_mon_q,  pend_mon_d;

   logic                    wall_hit_q,    wall_hit_d;
   logic                    coin_taken_q,  coin_taken_d;
   logic                    monster_hit_q, monster_hit_d;
   logic                    overflow_q,    overflow_d;
   logic [HW-1:0]           holdoff_q,     holdoff_d;

   logic [CODE_W-1:0]       mem_q [FIFO_DEPTH];
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [AW:0]             count_q,  count_d;

   logic                    acc_wall, acc_coin;
   logic [NUM_MONSTERS-1:0] acc_mon;
   logic                    fw_eff, fc_eff, fmh_eff;
   logic [NUM_MONSTERS-1:0] fm_eff;

   logic                    sel_wall, sel_coin, have_pend;
   logic [NUM_MONSTERS-1:0] sel_mon;
   logic [CODE_W-1:0]       push_code;
   logic                    push, pop, full;
   logic                    clr_wall, clr_coin;
   logic [NUM_MONSTERS-1:0] clr_mon;

   assign collision_pacman         = dr_pacman & (dr_tiles | dr_bracket);
   assign collision_monster_tile   = dr_monster & {NUM_MONSTERS{dr_tiles | dr_bracket}};
   assign collision_monster_pacman = dr_monster & {NUM_MONSTERS{dr_pacman}};

   assign wallHit        = wall_hit_q;
   assign coinTaken      = coin_taken_q;
   assign monsterHit     = monster_hit_q;
   assign evt_overflow   = overflow_q;
   assign holdoff_active = (holdoff_q != '0);
   assign evt_valid      = (count_q != '0);
   assign evt_code       = mem_q[rd_ptr_q];

   // Acceptance: a collision coincident with startOfFrame sees the already-cleared flag.
   always_comb begin
      fw_eff  = flag_wall_q & ~startOfFrame;
      fc_eff  = flag_coin_q & ~startOfFrame;
      fm_eff  = flag_mon_q & {NUM_MONSTERS{~startOfFrame}};
      fmh_eff = flag_mhit_q & ~startOfFrame;

      acc_wall = dr_pacman & dr_tiles & ~fw_eff;
      acc_coin = dr_pacman & dr_coins & ~fc_eff;
      acc_mon  = collision_monster_pacman & ~fm_eff & {NUM_MONSTERS{~holdoff_active}};

      flag_wall_d = fw_eff | acc_wall;
      flag_coin_d = fc_eff | acc_coin;
      flag_mon_d  = fm_eff | acc_mon;
      flag_mhit_d = fmh_eff | (|acc_mon);

      wall_hit_d    = acc_wall;
      coin_taken_d  = acc_coin;
      monster_hit_d = (|acc_mon) & ~fmh_eff;
   end

   // Drain selection: lowest-index monster first, then coin, then wall.
   always_comb begin
      sel_mon   = '0;
      sel_coin  = 1'b0;
      sel_wall  = 1'b0;
      have_pend = 1'b0;
      push_code = '0;
      for (int i = 0; i < NUM_MONSTERS; i++) begin
         if (pend_mon_q[i] && !have_pend) begin
            sel_mon[i] = 1'b1;
            push_code  = {TYPE_MON, ID_W'(i)};
            have_pend  = 1'b1;
         end
      end
      if (!have_pend && pend_coin_q) begin
         sel_coin  = 1'b1;
         push_code = {TYPE_COIN, {ID_W{1'b0}}};
         have_pend = 1'b1;
      end else if (!have_pend && pend_wall_q) begin
         sel_wall  = 1'b1;
         push_code = {TYPE_WALL, {ID_W{1'b0}}};
         have_pend = 1'b1;
      end
   end

   // A full FIFO still takes a push when the head leaves in the same cycle.
   always_comb begin
      full = (count_q == DEPTH_C);
      pop  = evt_valid & evt_ready;
      push = have_pend & (~full | pop);

      clr_mon  = sel_mon & {NUM_MONSTERS{push}};
      clr_coin = sel_coin & push;
      clr_wall = sel_wall & push;

      pend_mon_d  = (pend_mon_q & ~clr_mon) | acc_mon;
      pend_coin_d = (pend_coin_q & ~clr_coin) | acc_coin;
      pend_wall_d = (pend_wall_q & ~clr_wall) | acc_wall;

      // A pending bit that drains this cycle frees its slot, so no loss in that case.
      overflow_d = (|(acc_mon & pend_mon_q & ~clr_mon)) |
                   (acc_coin & pend_coin_q & ~clr_coin) |
                   (acc_wall & pend_wall_q & ~clr_wall);

      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop)      count_d = count_q + AW1'(1);
      else if (pop && !push) count_d = count_q - AW1'(1);

      // Reload takes priority over the frame decrement.
      holdoff_d = holdoff_q;
      if (|acc_mon)                            holdoff_d = HOLD_LOAD;
      else if (startOfFrame && holdoff_q != '0) holdoff_d = holdoff_q - HW'(1);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         flag_wall_q   <= 1'b0;
         flag_coin_q   <= 1'b0;
         flag_mon_q    <= '0;
         flag_mhit_q   <= 1'b0;
         pend_wall_q   <= 1'b0;
         pend_coin_q   <= 1'b0;
         pend_mon_q    <= '0;
         wall_hit_q    <= 1'b0;
         coin_taken_q  <= 1'b0;
         monster_hit_q <= 1'b0;
         overflow_q    <= 1'b0;
         holdoff_q     <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         flag_wall_q   <= flag_wall_d;
         flag_coin_q   <= flag_coin_d;
         flag_mon_q    <= flag_mon_d;
         flag_mhit_q   <= flag_mhit_d;
         pend_wall_q   <= pend_wall_d;
         pend_coin_q   <= pend_coin_d;
         pend_mon_q    <= pend_mon_d;
         wall_hit_q    <= wall_hit_d;
         coin_taken_q  <= coin_taken_d;
         monster_hit_q <= monster_hit_d;
         overflow_q    <= overflow_d;
         holdoff_q     <= holdoff_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_ptr_q] <= push_code;
      end
   end

endmodule
